// File: rtl/tq_row_gather_32.sv
// Row collector for the 32-point permutation stage: gathers 4 samples per beat into
// a 4/8/16/32-lane row and presents it in parallel. Optional macro: TQ_GATHER_ZERO_PAD_EN.
module tq_row_gather_32 #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_size,
    input  logic                  i_inverse,
    input  logic [4*IN_W-1:0]     i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [32*OUT_W-1:0]   o_data,
    output logic [1:0]            o_size,
    output logic                  o_inverse,
    output logic                  o_enable
);

    typedef enum logic {ST_FILL, ST_PEND} state_t;

    state_t             state_q, state_d;
    logic [2:0]         beat_q, beat_d;
    logic [1:0]         row_size_q, row_size_d;
    logic               row_inv_q, row_inv_d;
    logic [OUT_W-1:0]   fill_q [32];
    logic [OUT_W-1:0]   fill_d [32];
    logic [OUT_W-1:0]   out_q [32];
    logic [OUT_W-1:0]   out_d [32];
    logic               out_valid_q, out_valid_d;
    logic [1:0]         out_size_q, out_size_d;
    logic               out_inv_q, out_inv_d;

    logic [OUT_W-1:0]   beat_lane [4];
    logic               accept;
    logic               last_beat;
    logic               out_free;
    logic               load;
    logic [1:0]         cur_size;
    logic               cur_inv;
    logic [2:0]         last_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sext
            logic signed [IN_W-1:0] samp;
            assign samp          = i_data[gi*IN_W +: IN_W];
            assign beat_lane[gi] = OUT_W'(samp);
        end
        for (gi = 0; gi < 32; gi++) begin : g_out
            assign o_data[gi*OUT_W +: OUT_W] = out_q[gi];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        row_size_d  = row_size_q;
        row_inv_d   = row_inv_q;
        fill_d      = fill_q;
        out_d       = out_q;
        out_size_d  = out_size_q;
        out_inv_d   = out_inv_q;
        load        = 1'b0;

        // Size and direction come straight from the port on beat 0 only.
        cur_size  = (beat_q == 3'd0) ? i_size    : row_size_q;
        cur_inv   = (beat_q == 3'd0) ? i_inverse : row_inv_q;
        last_idx  = 3'((4'd1 << cur_size) - 4'd1);
        accept    = i_valid && (state_q == ST_FILL);
        last_beat = (beat_q == last_idx);
        out_free  = !out_valid_q || i_ready;

        if (accept) begin
`ifdef TQ_GATHER_ZERO_PAD_EN
            // Clearing at row start keeps every lane beyond the row length at zero.
            if (beat_q == 3'd0) begin
                for (int l = 4; l < 32; l++) begin
                    fill_d[l] = '0;
                end
            end
`endif
            for (int k = 0; k < 4; k++) begin
                fill_d[{beat_q, 2'(k)}] = beat_lane[k];
            end
            if (beat_q == 3'd0) begin
                row_size_d = i_size;
                row_inv_d  = i_inverse;
            end
            if (last_beat) begin
                beat_d = 3'd0;
                if (out_free) begin
                    load = 1'b1;
                end else begin
                    state_d = ST_PEND;
                end
            end else begin
                beat_d = beat_q + 3'd1;
            end
        end else if (state_q == ST_PEND && out_free) begin
            load    = 1'b1;
            state_d = ST_FILL;
        end

        if (load) begin
            out_d      = fill_d;
            out_size_d = cur_size;
            out_inv_d  = cur_inv;
        end
        if (state_q == ST_PEND) begin
            out_size_d = load ? row_size_q : out_size_d;
            out_inv_d  = load ? row_inv_q  : out_inv_d;
        end

        out_valid_d = load ? 1'b1 : (i_ready ? 1'b0 : out_valid_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            beat_q      <= 3'd0;
            row_size_q  <= 2'd0;
            row_inv_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_size_q  <= 2'd0;
            out_inv_q   <= 1'b0;
            for (int l = 0; l < 32; l++) begin
                fill_q[l] <= '0;
                out_q[l]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            row_size_q  <= row_size_d;
            row_inv_q   <= row_inv_d;
            out_valid_q <= out_valid_d;
            out_size_q  <= out_size_d;
            out_inv_q   <= out_inv_d;
            for (int l = 0; l < 32; l++) begin
                fill_q[l] <= fill_d[l];
                out_q[l]  <= out_d[l];
            end
        end
    end

    assign o_ready   = (state_q == ST_FILL);
    assign o_valid   = out_valid_q;
    assign o_size    = out_size_q;
    assign o_inverse = out_inv_q;
    assign o_enable  = out_valid_q && (out_size_q == 2'd3);

endmodule

// File: tb/tb_tq_row_gather_32.sv
// Directed bench for tq_row_gather_32; lane-padding checks are active when
// TQ_GATHER_ZERO_PAD_EN is defined.
module tb_tq_row_gather_32;

    localparam int IN_W  = 16;
    localparam int OUT_W = 28;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_valid;
    logic                 o_ready;
    logic [1:0]           i_size;
    logic                 i_inverse;
    logic [4*IN_W-1:0]    i_data;
    logic                 o_valid;
    logic                 i_ready;
    logic [32*OUT_W-1:0]  o_data;
    logic [1:0]           o_size;
    logic                 o_inverse;
    logic                 o_enable;

    int checks = 0;
    int errors = 0;

    tq_row_gather_32 #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_size(i_size), .i_inverse(i_inverse), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_size(o_size), .o_inverse(o_inverse), .o_enable(o_enable)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] lane(input int k);
        return o_data[k*OUT_W +: OUT_W];
    endfunction

    // One beat presented for exactly one edge; returns 1 time unit after that edge.
    task automatic beat(input logic [1:0] sz, input logic inv,
                        input int d0, input int d1, input int d2, input int d3);
        i_valid   = 1'b1;
        i_size    = sz;
        i_inverse = inv;
        i_data    = {d3[15:0], d2[15:0], d1[15:0], d0[15:0]};
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        $display("beat size=%0d inv=%0d data=%0d,%0d,%0d,%0d -> o_valid=%0b o_ready=%0b lane0=%0h",
                 sz, inv, d0, d1, d2, d3, o_valid, o_ready, lane(0));
    endtask

    task automatic idle();
        i_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_size = 2'd0; i_inverse = 1'b0; i_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
        checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_data got nonzero exp=0"); end
        checks++; if (o_size !== 2'd0) begin errors++; $display("FAIL reset_size got=%0d exp=0", o_size); end
        checks++; if (o_inverse !== 1'b0) begin errors++; $display("FAIL reset_inv got=%0b exp=0", o_inverse); end
        checks++; if (o_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%0b exp=0", o_enable); end
        rst = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", o_ready); end
    endtask

    task automatic test_reset_mid_row();
        i_ready = 1'b1;
        beat(2'd3, 1'b1, 100, 101, 102, 103);
        beat(2'd3, 1'b1, 104, 105, 106, 107);
        beat(2'd3, 1'b1, 108, 109, 110, 111);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        beat(2'd0, 1'b0, 1, 2, 3, 4);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL midrst_valid got=%0b exp=1", o_valid); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lane(k) !== OUT_W'(k + 1)) begin
                errors++; $display("FAIL midrst_lane%0d got=%0h exp=%0h", k, lane(k), k + 1);
            end
        end
        checks++; if (o_size !== 2'd0) begin errors++; $display("FAIL midrst_size got=%0d exp=0", o_size); end
        checks++; if (o_inverse !== 1'b0) begin errors++; $display("FAIL midrst_inv got=%0b exp=0", o_inverse); end
        idle();
    endtask

    task automatic test_size32();
        i_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            beat(2'd3, 1'b0, 4*b, 4*b + 1, 4*b + 2, 4*b + 3);
            if (b < 7) begin
                checks++;
                if (o_valid !== 1'b0) begin errors++; $display("FAIL s32_early_valid beat=%0d got=%0b exp=0", b, o_valid); end
            end
        end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL s32_valid got=%0b exp=1", o_valid); end
        checks++; if (o_enable !== 1'b1) begin errors++; $display("FAIL s32_enable got=%0b exp=1", o_enable); end
        checks++; if (o_size !== 2'd3) begin errors++; $display("FAIL s32_size got=%0d exp=3", o_size); end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (lane(k) !== OUT_W'(k)) begin
                errors++; $display("FAIL s32_lane%0d got=%0h exp=%0h", k, lane(k), k);
            end
        end
        idle();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL s32_one_cycle got=%0b exp=0", o_valid); end
        checks++; if (o_enable !== 1'b0) begin errors++; $display("FAIL s32_enable_off got=%0b exp=0", o_enable); end
    endtask

    task automatic test_size4_back_to_back();
        i_ready = 1'b1;
        beat(2'd0, 1'b0, -1, -2, -3, -4);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL s4_valid1 got=%0b exp=1", o_valid); end
        checks++; if (lane(0) !== 28'hFFFFFFF) begin errors++; $display("FAIL s4_lane0a got=%0h exp=fffffff", lane(0)); end
        checks++; if (lane(3) !== 28'hFFFFFFC) begin errors++; $display("FAIL s4_lane3a got=%0h exp=ffffffc", lane(3)); end
        checks++; if (o_enable !== 1'b0) begin errors++; $display("FAIL s4_enable got=%0b exp=0", o_enable); end
        beat(2'd0, 1'b0, 5, 6, 7, 8);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL s4_valid2 got=%0b exp=1", o_valid); end
        checks++; if (lane(0) !== 28'd5) begin errors++; $display("FAIL s4_lane0b got=%0h exp=5", lane(0)); end
        checks++; if (lane(3) !== 28'd8) begin errors++; $display("FAIL s4_lane3b got=%0h exp=8", lane(3)); end
        idle();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL s4_drained got=%0b exp=0", o_valid); end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        beat(2'd1, 1'b0, 10, 11, 12, 13);
        beat(2'd1, 1'b0, 14, 15, 16, 17);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_row1_valid got=%0b exp=1", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_row1 got=%0b exp=1", o_ready); end
        checks++; if (lane(7) !== 28'd17) begin errors++; $display("FAIL bp_row1_lane7 got=%0h exp=11", lane(7)); end
        beat(2'd1, 1'b1, 20, 21, 22, 23);
        beat(2'd1, 1'b1, 24, 25, 26, 27);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_pend_ready got=%0b exp=0", o_ready); end
        idle();
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_pend_hold got=%0b exp=0", o_ready); end
        checks++; if (lane(0) !== 28'd10) begin errors++; $display("FAIL bp_row1_held got=%0h exp=a", lane(0)); end
        checks++; if (o_inverse !== 1'b0) begin errors++; $display("FAIL bp_row1_inv got=%0b exp=0", o_inverse); end
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_row2_valid got=%0b exp=1", o_valid); end
        checks++; if (lane(0) !== 28'd20) begin errors++; $display("FAIL bp_row2_lane0 got=%0h exp=14", lane(0)); end
        checks++; if (lane(7) !== 28'd27) begin errors++; $display("FAIL bp_row2_lane7 got=%0h exp=1b", lane(7)); end
        checks++; if (o_inverse !== 1'b1) begin errors++; $display("FAIL bp_row2_inv got=%0b exp=1", o_inverse); end
        checks++; if (o_size !== 2'd1) begin errors++; $display("FAIL bp_row2_size got=%0d exp=1", o_size); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%0b exp=1", o_ready); end
        idle();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%0b exp=0", o_valid); end
    endtask

    task automatic test_drain_and_load();
        i_ready = 1'b0;
        beat(2'd0, 1'b0, 30, 31, 32, 33);
        checks++; if (lane(0) !== 28'd30) begin errors++; $display("FAIL dl_rowa got=%0h exp=1e", lane(0)); end
        beat(2'd1, 1'b0, 40, 41, 42, 43);
        i_ready = 1'b1;
        beat(2'd1, 1'b0, 44, 45, 46, 47);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL dl_valid got=%0b exp=1", o_valid); end
        checks++; if (lane(0) !== 28'd40) begin errors++; $display("FAIL dl_lane0 got=%0h exp=28", lane(0)); end
        checks++; if (lane(7) !== 28'd47) begin errors++; $display("FAIL dl_lane7 got=%0h exp=2f", lane(7)); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL dl_ready got=%0b exp=1", o_ready); end
        idle();
    endtask

    task automatic test_fields_and_padding();
        i_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            beat(2'd3, 1'b0, 7, 7, 7, 7);
        end
        idle();
        beat(2'd2, 1'b1, 50, 51, 52, 53);
        beat(2'd0, 1'b0, 54, 55, 56, 57);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fp_size_ignored got=%0b exp=0", o_valid); end
        beat(2'd0, 1'b0, 58, 59, 60, 61);
        beat(2'd1, 1'b0, 62, 63, 64, 65);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL fp_valid got=%0b exp=1", o_valid); end
        checks++; if (o_inverse !== 1'b1) begin errors++; $display("FAIL fp_inverse got=%0b exp=1", o_inverse); end
        checks++; if (o_size !== 2'd2) begin errors++; $display("FAIL fp_size got=%0d exp=2", o_size); end
        checks++; if (o_enable !== 1'b0) begin errors++; $display("FAIL fp_enable got=%0b exp=0", o_enable); end
        checks++; if (lane(15) !== 28'd65) begin errors++; $display("FAIL fp_lane15 got=%0h exp=41", lane(15)); end
`ifdef TQ_GATHER_ZERO_PAD_EN
        for (int k = 16; k < 32; k++) begin
            checks++;
            if (lane(k) !== 28'd0) begin errors++; $display("FAIL fp_pad_lane%0d got=%0h exp=0", k, lane(k)); end
        end
`endif
        idle();
    endtask

    initial begin
        test_reset();
        test_reset_mid_row();
        test_size32();
        test_size4_back_to_back();
        test_backpressure();
        test_drain_and_load();
        test_fields_and_padding();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
